// File: rtl/pulse_source_pkg.sv
// pulse_source_pkg: shared definitions for the pulse source sequencer.
//
// Contents:
//   - CntWDef / LvlWDef : default counter and level-code widths.
//   - ContEn            : 1 when continuous mode is compiled in.
//   - state_t + St*     : FSM state encoding (IDLE, HIGH, LOW, DONE).
//   - cfg_t             : the latched train configuration record.
//   - is_degenerate()   : tells whether a configuration emits no pulses.
//
// Build option:
//   PULSE_SOURCE_CONT_EN - when defined, n_pulses==0 selects a continuous train
//                          that runs until abort. When undefined, n_pulses==0
//                          completes at once with no pulses.
package pulse_source_pkg;

  localparam int unsigned CntWDef = 16;
  localparam int unsigned LvlWDef = 8;

`ifdef PULSE_SOURCE_CONT_EN
  localparam bit ContEn = 1'b1;
`else
  localparam bit ContEn = 1'b0;
`endif

  // FSM encoding, kept as plain constants so legacy code can compare raw codes.
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StHigh = 2'd1;
  localparam state_t StLow  = 2'd2;
  localparam state_t StDone = 2'd3;

  // Configuration captured when a train is accepted. Field widths follow the
  // package defaults, which the top-level parameters also default to.
  typedef struct packed {
    logic [CntWDef-1:0] period;
    logic [CntWDef-1:0] width;
    logic [CntWDef-1:0] n_pulses;
    logic [LvlWDef-1:0] level_hi;
    logic [LvlWDef-1:0] level_lo;
  } cfg_t;

  // A train with no period, or with no pulses and no continuous mode, goes
  // straight to DONE without producing a high phase.
  function automatic logic is_degenerate(input logic [CntWDef-1:0] period,
                                         input logic [CntWDef-1:0] n_pulses);
    return (period == '0) || ((n_pulses == '0) && !ContEn);
  endfunction

endpackage

// File: rtl/pulse_phase_cnt.sv
// pulse_phase_cnt: phase and pulse counters for the pulse source sequencer.
//
// The phase counter runs 0..period-1 inside every period. The pulse counter
// counts completed periods. Both clear when a new train is accepted and
// only advance while the train is running.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear      in   zero both counters (train accepted)
//   run        in   advance the counters this cycle
//   period     in   latched cycles per period (non-zero while running)
//   width      in   latched high cycles per period
//   n_pulses   in   latched number of periods (0 = continuous when enabled)
//   wrap       out  phase is on the last cycle of its period
//   term       out  the period now in progress is the final one
//   next_high  out  the phase value after this edge falls in the high part
//
// Build option: PULSE_SOURCE_CONT_EN (through pulse_source_pkg::ContEn) freezes
// the pulse counter and suppresses term when n_pulses==0.
module pulse_phase_cnt
  import pulse_source_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] n_pulses,
  output logic             wrap,
  output logic             term,
  output logic             next_high
);

  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic [CNT_W-1:0] pulses_inc;
  logic [CNT_W-1:0] phase_next;
  logic [CNT_W-1:0] hi_lim;
  logic             cont;

  assign cont = ContEn && (n_pulses == '0);

  assign wrap = (phase_q == (period - CNT_W'(1)));

  // pulses_q < n_pulses holds while running, so the increment cannot overflow.
  assign pulses_inc = pulses_q + CNT_W'(1);
  assign term       = !cont && (pulses_inc == n_pulses);

  assign phase_next = wrap ? '0 : (phase_q + CNT_W'(1));

  // A width at or above the period keeps the whole period high.
  assign hi_lim    = (width < period) ? width : period;
  assign next_high = (phase_next < hi_lim);

  always_comb begin
    phase_d  = phase_q;
    pulses_d = pulses_q;
    if (clear) begin
      phase_d  = '0;
      pulses_d = '0;
    end else if (run) begin
      phase_d = phase_next;
      if (wrap && !cont) begin
        pulses_d = pulses_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      pulses_q <= '0;
    end else begin
      phase_q  <= phase_d;
      pulses_q <= pulses_d;
    end
  end

endmodule

// File: rtl/pulse_source_seq.sv
// pulse_source_seq: clocked sequencer producing a train of rectangular pulses
// as a level code for a downstream DC source primitive.
//
// A start in IDLE latches the configuration; the train then alternates between
// HIGH (level_hi) and LOW (level_lo) phases for n_pulses periods, spends one
// cycle in DONE, and returns to IDLE. All outputs are registered and change on
// the same edge as the state.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request a train; only looked at in IDLE (wins over abort)
//   abort      in   end the running train; DONE follows on the next cycle
//   period     in   cycles per pulse period
//   width      in   high cycles per period
//   n_pulses   in   periods to emit
//   level_hi   in   code for the high phase
//   level_lo   in   code for the low phase, DONE and IDLE
//   out_level  out  level code to the source
//   out_high   out  1 during the high phase
//   busy       out  1 in HIGH or LOW
//   done       out  one-cycle pulse when the train ends
//
// Build option: PULSE_SOURCE_CONT_EN makes n_pulses==0 a continuous train that
// runs until abort.
module pulse_source_seq
  import pulse_source_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned LVL_W = LvlWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [LVL_W-1:0] level_hi,
  input  logic [LVL_W-1:0] level_lo,
  output logic [LVL_W-1:0] out_level,
  output logic             out_high,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [LVL_W-1:0] out_level_q, out_level_d;
  logic             out_high_q, busy_q, done_q;

  logic accept;
  logic running;
  logic wrap, term, next_high;

  assign accept  = (state_q == StIdle) && start;
  assign running = (state_q == StHigh) || (state_q == StLow);

  // Configuration latch: inputs are only looked at when a train is accepted.
  always_comb begin
    cfg_d = cfg_q;
    if (accept) begin
      cfg_d.period   = period;
      cfg_d.width    = width;
      cfg_d.n_pulses = n_pulses;
      cfg_d.level_hi = level_hi;
      cfg_d.level_lo = level_lo;
    end
  end

  pulse_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .run       (running && !abort),
    .period    (cfg_q.period),
    .width     (cfg_q.width),
    .n_pulses  (cfg_q.n_pulses),
    .wrap      (wrap),
    .term      (term),
    .next_high (next_high)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_degenerate(period, n_pulses)) begin
            state_d = StDone;
          end else if (width == '0) begin
            state_d = StLow;
          end else begin
            state_d = StHigh;
          end
        end
      end
      StHigh, StLow: begin
        if (abort || (wrap && term)) begin
          state_d = StDone;
        end else begin
          state_d = next_high ? StHigh : StLow;
        end
      end
      StDone: begin
        // A start seen here is deliberately dropped.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs follow the next state, using the freshly latched codes when a
  // train is being accepted on this edge.
  assign out_level_d = (state_d == StHigh) ? cfg_d.level_hi : cfg_d.level_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cfg_q       <= '0;
      out_level_q <= '0;
      out_high_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      out_level_q <= out_level_d;
      out_high_q  <= (state_d == StHigh);
      busy_q      <= (state_d == StHigh) || (state_d == StLow);
      done_q      <= (state_d == StDone);
    end
  end

  assign out_level = out_level_q;
  assign out_high  = out_high_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_source_seq.sv
// tb_pulse_source_seq: directed self-checking bench for pulse_source_seq.
// Cycle n is the interval after the n-th rising edge following the cycle in
// which start was held (cycle 0). Outputs are sampled 1 time unit after edges.
module tb_pulse_source_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] period;
  logic [15:0] width;
  logic [15:0] n_pulses;
  logic [7:0]  level_hi;
  logic [7:0]  level_lo;
  logic [7:0]  out_level;
  logic        out_high;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  pulse_source_seq #(
    .CNT_W (16),
    .LVL_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .period    (period),
    .width     (width),
    .n_pulses  (n_pulses),
    .level_hi  (level_hi),
    .level_lo  (level_lo),
    .out_level (out_level),
    .out_high  (out_high),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] lvl, input logic high,
                           input logic bsy, input logic dn);
    check_eq({tag, ".level"}, 32'(out_level), 32'(lvl));
    check_eq({tag, ".high"},  32'(out_high),  32'(high));
    check_eq({tag, ".busy"},  32'(busy),      32'(bsy));
    check_eq({tag, ".done"},  32'(done),      32'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic program_train(input logic [15:0] p, input logic [15:0] w, input logic [15:0] n,
                               input logic [7:0] hi, input logic [7:0] lo);
    period   = p;
    width    = w;
    n_pulses = n;
    level_hi = hi;
    level_lo = lo;
    start    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    period   = '0;
    width    = '0;
    n_pulses = '0;
    level_hi = '0;
    level_lo = '0;
    tick();
    tick();
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("idle_after_reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic train; abort alongside start must lose, later input edits ignored.
    program_train(16'd4, 16'd1, 16'd3, 8'hC8, 8'h10);
    abort = 1'b1;
    tick();
    start    = 1'b0;
    abort    = 1'b0;
    period   = 16'd7;
    level_hi = 8'hFF;
    level_lo = 8'h01;
    for (int c = 1; c <= 12; c++) begin
      check_out($sformatf("basic_c%0d", c), (((c - 1) % 4) == 0) ? 8'hC8 : 8'h10,
                ((c - 1) % 4) == 0, 1'b1, 1'b0);
      tick();
    end
    check_out("basic_c13", 8'h10, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("basic_c14", 8'h10, 1'b0, 1'b0, 1'b0);

    // width = 0: low for the whole train.
    program_train(16'd3, 16'd0, 16'd2, 8'h77, 8'h22);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check_out($sformatf("w0_c%0d", c), 8'h22, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check_out("w0_c7", 8'h22, 1'b0, 1'b0, 1'b1);
    tick();

    // width > period: high for the whole train.
    program_train(16'd3, 16'd5, 16'd2, 8'h77, 8'h22);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check_out($sformatf("w5_c%0d", c), 8'h77, 1'b1, 1'b1, 1'b0);
      tick();
    end
    check_out("w5_c7", 8'h22, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("w5_c8", 8'h22, 1'b0, 1'b0, 1'b0);

    // period = 0 is degenerate.
    program_train(16'd0, 16'd2, 16'd3, 8'h44, 8'h33);
    tick();
    start = 1'b0;
    check_out("p0_c1", 8'h33, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("p0_c2", 8'h33, 1'b0, 1'b0, 1'b0);

`ifndef PULSE_SOURCE_CONT_EN
    // n_pulses = 0 is degenerate without continuous mode.
    program_train(16'd5, 16'd2, 16'd0, 8'h44, 8'h39);
    tick();
    start = 1'b0;
    check_out("n0_c1", 8'h39, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("n0_c2", 8'h39, 1'b0, 1'b0, 1'b0);
`endif

    // Abort at cycle 7, start held in DONE must be dropped.
    program_train(16'd10, 16'd5, 16'd4, 8'hA0, 8'h05);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check_out($sformatf("abort_c%0d", c), (c <= 5) ? 8'hA0 : 8'h05, c <= 5, 1'b1, 1'b0);
      if (c == 7) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check_out("abort_c8", 8'h05, 1'b0, 1'b0, 1'b1);
    program_train(16'd3, 16'd1, 16'd2, 8'hEE, 8'h66);
    tick();
    start = 1'b0;
    check_out("abort_c9", 8'h05, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("abort_c10", 8'h05, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_out("abort_idle", 8'h05, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a high phase.
    program_train(16'd4, 16'd3, 16'd2, 8'h55, 8'h11);
    tick();
    start = 1'b0;
    check_out("arst_pre", 8'h55, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_out("arst_now", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("arst_held", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("arst_rel", 8'h00, 1'b0, 1'b0, 1'b0);
    program_train(16'd2, 16'd1, 16'd2, 8'h99, 8'h33);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check_out($sformatf("fresh_c%0d", c), ((c % 2) == 1) ? 8'h99 : 8'h33, (c % 2) == 1,
                1'b1, 1'b0);
      tick();
    end
    check_out("fresh_c5", 8'h33, 1'b0, 1'b0, 1'b1);
    tick();

`ifdef PULSE_SOURCE_CONT_EN
    // Continuous mode: alternate until abort.
    program_train(16'd2, 16'd1, 16'd0, 8'hE0, 8'h0E);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      check_out($sformatf("cont_c%0d", c), ((c % 2) == 1) ? 8'hE0 : 8'h0E, (c % 2) == 1,
                1'b1, 1'b0);
      if (c == 100) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    check_out("cont_done", 8'h0E, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("cont_idle", 8'h0E, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
